// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: one CHUNK-bit carry slice per stage, valid/ready handshake.
// Optional macro PIPE_ADDER_OVF_EN adds a signed-overflow output aligned with sum.
module pipe_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry
`ifdef PIPE_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int NB    = (STAGES > 1) ? STAGES - 1 : 1;

   if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipe_adder: STAGES must be >= 1 and divide WIDTH");
   end

   function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y,
                                                input logic             c);
      chunk_add = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
   endfunction

   logic             adv_s;
   logic [WIDTH-1:0] a_g_s;
   logic [WIDTH-1:0] b_g_s;
   logic             ci_g_s;

   logic [WIDTH-1:0] acc_in_s [STAGES];
   logic [WIDTH-1:0] b_in_s   [STAGES];
   logic             c_in_s   [STAGES];
   logic             v_in_s   [STAGES];
   logic [CHUNK:0]   part_s   [STAGES];
   logic [WIDTH-1:0] acc_s    [STAGES];
   logic             c_s      [STAGES];
   logic             v_s      [STAGES];
   logic [WIDTH-1:0] b_s      [NB];

   assign adv_s     = !v_s[STAGES-1] | out_ready;
   assign in_ready  = adv_s;
   assign out_valid = v_s[STAGES-1];
   assign sum       = acc_s[STAGES-1];
   assign carry     = c_s[STAGES-1];

   // Operand conditioning: zero the data on bubbles so X never enters the pipe.
   always_comb begin
      a_g_s  = {WIDTH{1'b0}};
      b_g_s  = {WIDTH{1'b0}};
      ci_g_s = 1'b0;
      if (in_valid) begin
         a_g_s = a;
         if (sub) begin
            b_g_s  = ~b;
            ci_g_s = ~ci;
         end else begin
            b_g_s  = b;
            ci_g_s = ci;
         end
      end else begin
         a_g_s  = {WIDTH{1'b0}};
         b_g_s  = {WIDTH{1'b0}};
         ci_g_s = 1'b0;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] acc_r;
      logic [WIDTH-1:0] acc_nx_s;
      logic             c_r;
      logic             v_r;

      if (k == 0) begin : g_src
         assign acc_in_s[k] = a_g_s;
         assign b_in_s[k]   = b_g_s;
         assign c_in_s[k]   = ci_g_s;
         assign v_in_s[k]   = in_valid;
      end else begin : g_src
         assign acc_in_s[k] = acc_s[k-1];
         assign b_in_s[k]   = b_s[k-1];
         assign c_in_s[k]   = c_s[k-1];
         assign v_in_s[k]   = v_s[k-1];
      end

      assign part_s[k] = chunk_add(acc_in_s[k][CHUNK-1:0], b_in_s[k][CHUNK-1:0], c_in_s[k]);

      // The accumulator rotates right: the unused a-chunk is consumed at the bottom
      // and the finished sum chunk enters at the top, so after the last stage the
      // word is the deskewed sum in natural bit order.
      if (STAGES == 1) begin : g_one
         assign acc_nx_s = part_s[k][CHUNK-1:0];
      end else begin : g_rot
         assign acc_nx_s = {part_s[k][CHUNK-1:0], acc_in_s[k][WIDTH-1:CHUNK]};
      end

      // Stage register: partial result, chunk carry and valid, stalled by adv.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            acc_r <= {WIDTH{1'b0}};
            c_r   <= 1'b0;
            v_r   <= 1'b0;
         end else if (adv_s) begin
            acc_r <= acc_nx_s;
            c_r   <= part_s[k][CHUNK];
            v_r   <= v_in_s[k];
         end
      end

      assign acc_s[k] = acc_r;
      assign c_s[k]   = c_r;
      assign v_s[k]   = v_r;

      if (k < STAGES - 1) begin : g_skew
         logic [WIDTH-1:0] b_r;

         // Skew register for the effective b operand, shifted so the next chunk sits at the bottom.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               b_r <= {WIDTH{1'b0}};
            end else if (adv_s) begin
               b_r <= b_in_s[k] >> CHUNK;
            end
         end

         assign b_s[k] = b_r;
      end

`ifdef PIPE_ADDER_OVF_EN
      if (k == STAGES - 1) begin : g_ovf
         logic ovf_r;
         logic ovf_nx_s;

         // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
         assign ovf_nx_s = (acc_in_s[k][CHUNK-1] ^ b_in_s[k][CHUNK-1] ^ part_s[k][CHUNK-1])
                           ^ part_s[k][CHUNK];

         // Overflow flag register, aligned with the final sum.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_r <= 1'b0;
            end else if (adv_s) begin
               ovf_r <= ovf_nx_s;
            end
         end

         assign ovf = ovf_r;
      end
`endif
   end

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, STAGES=4) with a queue scoreboard.
module tb_pipe_adder;

   localparam int W = 16;
   localparam int S = 4;
`ifdef PIPE_ADDER_OVF_EN
   localparam logic OVF = 1'b1;
`else
   localparam logic OVF = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          ci;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          carry;
   logic          ovf_s;

   logic [17:0]   sb [$];
   int            total = 0;
   int            bad = 0;

   pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry)
`ifdef PIPE_ADDER_OVF_EN
      ,
      .ovf       (ovf_s)
`endif
   );

`ifndef PIPE_ADDER_OVF_EN
   assign ovf_s = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {ovf, carry, sum} from whole-word arithmetic.
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic s);
      logic [16:0] r;
      logic [15:0] ye;
      logic        ce;
      logic        o;
      ye = s ? ~y : y;
      ce = s ? ~c : c;
      r  = {1'b0, x} + {1'b0, ye} + {16'h0000, ce};
      o  = (x[15] == ye[15]) && (r[15] != x[15]);
      return {o & OVF, r};
   endfunction

   // One cycle: drive inputs, note consumption/acceptance, advance to the next negedge.
   task automatic tick(input logic v, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tci, input logic tsub, input logic ordy,
                       output logic took, output logic hit, output logic rdy,
                       output logic [17:0] got, output logic [17:0] exp);
      in_valid  = v;
      a         = ta;
      b         = tb_;
      ci        = tci;
      sub       = tsub;
      out_ready = ordy;
      #1;
      rdy  = in_ready;
      took = out_valid && out_ready;
      got  = {ovf_s, carry, sum};
      hit  = 1'b0;
      exp  = 18'h00000;
      if (took && sb.size() > 0) begin
         exp = sb.pop_front();
         hit = 1'b1;
      end
      if (v && in_ready) sb.push_back(model(ta, tb_, tci, tsub));
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = 16'h0000; b = 16'h0000; ci = 1'b0; sub = 1'b0;
      #12;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (sum !== 16'h0000) begin bad++; $display("FAIL reset_sum got=%h exp=0000", sum); end
      total++; if ({ovf_s, carry} !== 2'b00) begin bad++; $display("FAIL reset_carry got=%b exp=00", {ovf_s, carry}); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_add();
      logic took, hit, rdy; logic [17:0] got, exp;
      int n = 0, lat = -1;
      for (int i = 0; i < 10; i++) begin
         tick(i == 0, 16'h000A, 16'h0005, 1'b1, 1'b0, 1'b1, took, hit, rdy, got, exp);
         if (took) begin
            n++; lat = i;
            total++; if (!hit || got !== exp) begin bad++; $display("FAIL basic_sb got=%h exp=%h hit=%0d", got, exp, hit); end
            total++; if (got !== 18'h00010) begin bad++; $display("FAIL basic_value got=%h exp=00010", got); end
         end
      end
      total++; if (n != 1 || lat != S) begin bad++; $display("FAIL basic_latency count=%0d cycle=%0d exp count=1 cycle=%0d", n, lat, S); end
   endtask

   task automatic test_ripple();
      logic took, hit, rdy; logic [17:0] got, exp;
      logic [15:0] va [2];
      logic [17:0] ec [2];
      int k = 0;
      va[0] = 16'hFFFF; va[1] = 16'h7FFF;
      ec[0] = 18'h10000;
      ec[1] = OVF ? 18'h28000 : 18'h08000;
      for (int i = 0; i < 10; i++) begin
         tick(i < 2, va[i % 2], 16'h0001, 1'b0, 1'b0, 1'b1, took, hit, rdy, got, exp);
         if (took) begin
            total++; if (!hit || got !== exp) begin bad++; $display("FAIL ripple_sb got=%h exp=%h hit=%0d", got, exp, hit); end
            if (k < 2) begin
               total++; if (got !== ec[k]) begin bad++; $display("FAIL ripple_value%0d got=%h exp=%h", k, got, ec[k]); end
            end
            k++;
         end
      end
      total++; if (k != 2) begin bad++; $display("FAIL ripple_count got=%0d exp=2", k); end
   endtask

   task automatic test_sub_wrap();
      logic took, hit, rdy; logic [17:0] got, exp;
      logic [15:0] va [2];
      logic [15:0] vb [2];
      logic        vc [2];
      logic [17:0] ec [2];
      int k = 0;
      va[0] = 16'h0003; vb[0] = 16'h0005; vc[0] = 1'b0; ec[0] = 18'h0FFFE;
      va[1] = 16'h0005; vb[1] = 16'h0003; vc[1] = 1'b1; ec[1] = 18'h10001;
      for (int i = 0; i < 10; i++) begin
         tick(i < 2, va[i % 2], vb[i % 2], vc[i % 2], 1'b1, 1'b1, took, hit, rdy, got, exp);
         if (took) begin
            total++; if (!hit || got !== exp) begin bad++; $display("FAIL sub_sb got=%h exp=%h hit=%0d", got, exp, hit); end
            if (k < 2) begin
               total++; if (got !== ec[k]) begin bad++; $display("FAIL sub_value%0d got=%h exp=%h", k, got, ec[k]); end
            end
            k++;
         end
      end
      total++; if (k != 2) begin bad++; $display("FAIL sub_count got=%0d exp=2", k); end
   endtask

   task automatic test_back_to_back();
      logic took, hit, rdy; logic [17:0] got, exp;
      logic [15:0] ev;
      int first = -1, last = -1, k = 0;
      for (int i = 0; i < 16; i++) begin
         tick(i < 8, 16'(i), 16'(i * 256), 1'b0, 1'b0, 1'b1, took, hit, rdy, got, exp);
         if (took) begin
            if (first < 0) first = i;
            last = i;
            ev = 16'(k * 257);
            total++; if (!hit || got !== exp) begin bad++; $display("FAIL stream_sb got=%h exp=%h hit=%0d", got, exp, hit); end
            total++; if (got !== {2'b00, ev}) begin bad++; $display("FAIL stream_value%0d got=%h exp=%h", k, got, {2'b00, ev}); end
            k++;
         end
      end
      total++; if (k != 8 || first != S || last != S + 7) begin
         bad++; $display("FAIL stream_timing count=%0d first=%0d last=%0d exp 8/%0d/%0d", k, first, last, S, S + 7);
      end
   endtask

   task automatic test_backpressure();
      logic took, hit, rdy; logic [17:0] got, exp, held;
      held = 18'h00000;
      for (int i = 0; i < 22; i++) begin
         tick(i < 10, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
              !(i >= 4 && i < 7), took, hit, rdy, got, exp);
         if (i == 4) held = got;
         if (i >= 4 && i < 7) begin
            total++; if (rdy !== 1'b0) begin bad++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", i, rdy); end
            total++; if (got !== held || out_valid !== 1'b1) begin
               bad++; $display("FAIL bp_hold cycle=%0d got=%h exp=%h valid=%b", i, got, held, out_valid);
            end
         end
         if (took) begin
            total++; if (!hit || got !== exp) begin bad++; $display("FAIL bp_sb got=%h exp=%h hit=%0d", got, exp, hit); end
         end
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_drain left=%0d exp=0", sb.size()); end
   endtask

   task automatic test_reset_midflight();
      logic took, hit, rdy; logic [17:0] got, exp;
      int n = 0, lat = -1;
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 16'h1234 + 16'(i), 16'h1111, 1'b0, 1'b0, 1'b1, took, hit, rdy, got, exp);
      end
      #2 rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || sum !== 16'h0000) begin
         bad++; $display("FAIL midrst_clear valid=%b sum=%h exp 0/0000", out_valid, sum);
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
      #1 rst_n = 1'b1;
      sb.delete();
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         tick(i == 0, 16'h0100, 16'h0023, 1'b1, 1'b0, 1'b1, took, hit, rdy, got, exp);
         if (took) begin
            n++; lat = i;
            total++; if (!hit || got !== 18'h00124) begin bad++; $display("FAIL midrst_value got=%h exp=00124 hit=%0d", got, hit); end
         end
      end
      total++; if (n != 1 || lat != S) begin bad++; $display("FAIL midrst_latency count=%0d cycle=%0d exp 1/%0d", n, lat, S); end
   endtask

   task automatic test_random();
      logic took, hit, rdy; logic [17:0] got, exp;
      logic v, r;
      for (int i = 0; i < 100; i++) begin
         v = (i < 80) ? ($urandom_range(0, 9) < 7) : 1'b0;
         r = (i < 80) ? ($urandom_range(0, 9) < 7) : 1'b1;
         tick(v, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), r, took, hit, rdy, got, exp);
         if (took) begin
            total++; if (!hit || got !== exp) begin bad++; $display("FAIL rand_sb cycle=%0d got=%h exp=%h hit=%0d", i, got, exp, hit); end
         end
      end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL rand_drain left=%0d exp=0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_ripple();
      test_sub_wrap();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
